// File: rtl/pipe_buf_pkg.sv
// Shared fetch-word layout and helpers for the fetch/decode elastic buffer.
package pipe_buf_pkg;

    localparam int FETCH_W   = 134;
    localparam int PC_MSB    = 112;
    localparam int PC_LSB    = 97;
    localparam int INSTR_MSB = 15;
    localparam int INSTR_LSB = 0;

    localparam logic [FETCH_W-1:0] NOP_FETCH = '0;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

    function automatic buf_op_e bufOp(input logic push, input logic pop);
        return buf_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: synchronous write, combinational read, no reset.
module pipe_buf_mem #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_fifo_buf.sv
// Elastic fetch-to-decode buffer: DEPTH-entry FIFO with valid/ready on both
// sides, synchronous flush for redirects, and a NOP word presented when empty.
module pipe_fifo_buf
    import pipe_buf_pkg::*;
#(
    parameter int               WIDTH    = FETCH_W,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] NOP_WORD = NOP_FETCH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           read_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_wrEn;
    logic [WIDTH-1:0] w_rdData;

    // in_ready comes from the registered count only, so a pop never opens a slot in the same cycle
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_wrEn    = w_push & reset & ~flush;
    assign count     = r_count;
    assign data_out  = out_valid ? w_rdData : NOP_WORD;

    pipe_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wrEn),
        .waddr (r_wrPtr),
        .wdata (read_in),
        .raddr (r_rdPtr),
        .rdata (w_rdData)
    );

    // Reset and flush share one path; storage is left alone since the output mask hides it
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case (bufOp(w_push, w_pop))
                OP_PUSH: r_count <= r_count + CNT_W'(1);
                OP_POP:  r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
